// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and the
// ALU-control helper that maps MIPS funct codes onto an op.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } md_state_e;

    // funct 011000..011011 are MULT/MULTU/DIV/DIVU; the low two bits are the op.
    function automatic logic is_md_funct(input logic [5:0] funct);
        return funct[5:2] == 4'b0110;
    endfunction

    function automatic md_op_e aludec_op(input logic [5:0] funct);
        return md_op_e'(funct[1:0]);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate: per-half for operands / div results,
// or across the full 2*W value for a product (wide=1, controlled by neg_lo).
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] x_hi,
    input  logic [W-1:0] x_lo,
    input  logic         neg_hi,
    input  logic         neg_lo,
    input  logic         wide,
    output logic [W-1:0] y_hi,
    output logic [W-1:0] y_lo
);
    logic [2*W-1:0] full;

    always_comb begin
        full = neg_lo ? -{x_hi, x_lo} : {x_hi, x_lo};
        if (wide) begin
            {y_hi, y_lo} = full;
        end else begin
            y_hi = neg_hi ? -x_hi : x_hi;
            y_lo = neg_lo ? -x_lo : x_lo;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with start/busy/done handshake.
// MULDIV_FAST_MUL_EN: multiplies complete in one cycle via a WIDTH x WIDTH multiplier.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;

    md_state_e        state;
    logic [1:0]       op_q;
    logic             sa_q, sb_q;
    logic [CW-1:0]    cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0] mc;
    logic [WIDTH-1:0] res_hi, res_lo, hi_q, lo_q;

    logic             is_div, is_sgn, a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs, fix_hi, fix_lo;
    logic [WIDTH:0]   add_sum, rem, diff;
    logic [2*WIDTH-1:0] mul_next, div_next;

    assign is_div = op[1];
    assign is_sgn = ~op[0];
    assign a_neg  = is_sgn & a[WIDTH-1];
    assign b_neg  = is_sgn & b[WIDTH-1];

    muldiv_sign_fix #(.W(WIDTH)) u_opnd (
        .x_hi(a), .x_lo(b), .neg_hi(a_neg), .neg_lo(b_neg), .wide(1'b0),
        .y_hi(a_abs), .y_lo(b_abs)
    );

    // Product negates as one 2*WIDTH value; remainder follows a, quotient a^b.
    muldiv_sign_fix #(.W(WIDTH)) u_res (
        .x_hi(acc[2*WIDTH-1:WIDTH]), .x_lo(acc[WIDTH-1:0]),
        .neg_hi(op_q[1] ? sa_q : sa_q ^ sb_q), .neg_lo(sa_q ^ sb_q), .wide(~op_q[1]),
        .y_hi(fix_hi), .y_lo(fix_lo)
    );

    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mc} : '0);
        mul_next = {add_sum, acc[WIDTH-1:1]};
        rem      = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = rem - {1'b0, mc};
        div_next = diff[WIDTH] ? {rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] prod;
    // Sign-extended operands make the truncated unsigned product correct for signed ops too.
    assign prod = {{WIDTH{a_neg}}, a} * {{WIDTH{b_neg}}, b};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= 2'b00;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mc     <= '0;
            res_hi <= '0;
            res_lo <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        op_q <= op;
                        sa_q <= a_neg;
                        sb_q <= b_neg;
                        cnt  <= CW'(WIDTH);
                        mc   <= is_div ? b_abs : a_abs;
                        acc  <= {{WIDTH{1'b0}}, is_div ? a_abs : b_abs};
                        if (is_div && b == '0) begin
                            res_hi <= a;
                            res_lo <= '1;
                            state  <= S_DONE;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!is_div) begin
                            {res_hi, res_lo} <= prod;
                            state            <= S_DONE;
`endif
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= op_q[1] ? div_next : mul_next;
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        res_hi <= fix_hi;
                        res_lo <= fix_lo;
                        state  <= S_DONE;
                    end
                end
                default: begin
                    if (!flush) begin
                        hi_q <= res_hi;
                        lo_q <= res_lo;
                    end
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // A flush landing in the DONE cycle must still suppress the pulse and the update.
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE) && !flush;
    assign hi   = done ? res_hi : hi_q;
    assign lo   = done ? res_lo : lo_q;

endmodule
